// File: rtl/fb_pkg.sv
// Shared types and the raster-op function for the double-buffered frame store.
package fb_pkg;

   // Widest pixel rop() can combine; callers size-cast to their own COLOR_W.
   localparam int unsigned ROP_MAX_W = 16;

   typedef enum logic [1:0] {
      WM_REPLACE = 2'b00,
      WM_AND     = 2'b01,
      WM_OR      = 2'b10,
      WM_XOR     = 2'b11
   } wmode_e;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      PEND  = 2'b01,
      DRAIN = 2'b10
   } swap_state_e;

   function automatic logic [ROP_MAX_W-1:0] rop(
      input logic [ROP_MAX_W-1:0] old,
      input logic [ROP_MAX_W-1:0] src,
      input wmode_e               mode
   );
      logic [ROP_MAX_W-1:0] res;
      res = src;
      case (mode)
         WM_REPLACE: res = src;
         WM_AND:     res = old & src;
         WM_OR:      res = old | src;
         WM_XOR:     res = old ^ src;
         default:    res = src;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/fb_dpram.sv
// Simple dual-port RAM: one write port, one read port with registered (read-first) data.
module fb_dpram
   import fb_pkg::*;
#(
   parameter int unsigned COLOR_W = 3,
   parameter int unsigned ADDR_W  = 17,
   parameter int unsigned DEPTH   = 76800
) (
   input  logic               i_clk,
   input  logic               i_we,
   input  logic [ADDR_W-1:0]  i_waddr,
   input  logic [COLOR_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0]  i_raddr,
   output logic [COLOR_W-1:0] o_rdata
);

   logic [COLOR_W-1:0] r_mem [DEPTH];
   logic [COLOR_W-1:0] r_rdata;

   // Contents are intentionally never reset so the array maps onto block RAM.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/fb_rop_dbuf.sv
// Double-buffered frame store: the display scans the front buffer, the drawer does raster-op
// read-modify-writes into the back buffer, and buffer swaps commit only at frame end.
module fb_rop_dbuf
   import fb_pkg::*;
#(
   parameter int unsigned COLOR_W = 3,
   parameter int unsigned H_RES   = 320,
   parameter int unsigned V_RES   = 240,
   parameter int unsigned ADDR_W  = 17
) (
   input  logic               i_clk,
   input  logic               i_reset_n,
   input  logic [ADDR_W-1:0]  i_scan_addr,
   input  logic               i_scan_active,
   input  logic               i_frame_end,
   output logic [COLOR_W-1:0] o_pix,
   input  logic               i_wvalid,
   output logic               o_wready,
   input  logic [ADDR_W-1:0]  i_waddr,
   input  logic [COLOR_W-1:0] i_wdata,
   input  logic [1:0]         i_wmode,
   input  logic               i_flush,
   output logic               o_swap_pending,
   output logic               o_swap_done,
   output logic               o_front_id,
   output logic               o_wr_oor
);

   localparam int unsigned     DEPTH   = H_RES * V_RES;
   localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);

   if ((64'd1 << ADDR_W) < 64'(DEPTH)) begin : g_bad_addr_w
      $error("ADDR_W too small for H_RES*V_RES");
   end
   if (COLOR_W > ROP_MAX_W) begin : g_bad_color_w
      $error("COLOR_W exceeds ROP_MAX_W");
   end

   swap_state_e        r_state, w_state_next;
   logic               w_commit;
   logic               r_flush_q, w_flush_rise;
   logic               r_front_id, r_swap_done;

   logic               w_accept;
   logic               r_s1_valid;
   logic [ADDR_W-1:0]  r_s1_addr;
   logic [COLOR_W-1:0] r_s1_data;
   wmode_e             r_s1_mode;
   logic               w_s1_we;
   logic [COLOR_W-1:0] w_back_rdata, w_old, w_new;

   logic               r_fwd_valid;
   logic [ADDR_W-1:0]  r_fwd_addr;
   logic [COLOR_W-1:0] r_fwd_data;

   logic               r_rd_sel, r_act_d1;
   logic [COLOR_W-1:0] r_pix;

   logic [ADDR_W-1:0]  w_raddr_a, w_raddr_b;
   logic [COLOR_W-1:0] w_rdata_a, w_rdata_b;
   logic               w_we_a, w_we_b;

   // Swap FSM
   assign w_flush_rise = i_flush & ~r_flush_q;

   always_comb begin
      w_state_next = r_state;
      w_commit     = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_flush_rise) w_state_next = PEND;
         end
         PEND: begin
            if (!r_s1_valid) w_state_next = DRAIN;
         end
         DRAIN: begin
            if (i_frame_end) begin
               w_state_next = IDLE;
               w_commit     = 1'b1;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state     <= IDLE;
         r_flush_q   <= 1'b0;
         r_front_id  <= 1'b0;
         r_swap_done <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_flush_q   <= i_flush;
         r_front_id  <= r_front_id ^ w_commit;
         r_swap_done <= w_commit;
      end
   end

   assign o_wready       = (r_state == IDLE);
   assign o_swap_pending = (r_state != IDLE);
   assign o_swap_done    = r_swap_done;
   assign o_front_id     = r_front_id;

   // Write pipeline: S0 is the accept cycle (back-buffer read issued), S1 modifies and writes.
   assign w_accept = i_wvalid & o_wready;
   assign w_s1_we  = r_s1_valid & ({1'b0, r_s1_addr} < DEPTH_A);
   assign o_wr_oor = r_s1_valid & ~({1'b0, r_s1_addr} < DEPTH_A);

   // The back buffer is the one not selected for display when the read was issued.
   assign w_back_rdata = r_rd_sel ? w_rdata_a : w_rdata_b;
   // RAM reads are read-first, so a same-address write in the previous S1 must be forwarded.
   assign w_old = (r_fwd_valid && (r_fwd_addr == r_s1_addr)) ? r_fwd_data : w_back_rdata;
   assign w_new = COLOR_W'(rop(ROP_MAX_W'(w_old), ROP_MAX_W'(r_s1_data), r_s1_mode));

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_s1_valid  <= 1'b0;
         r_s1_addr   <= '0;
         r_s1_data   <= '0;
         r_s1_mode   <= WM_REPLACE;
         r_fwd_valid <= 1'b0;
         r_fwd_addr  <= '0;
         r_fwd_data  <= '0;
      end else begin
         r_s1_valid <= w_accept;
         if (w_accept) begin
            r_s1_addr <= i_waddr;
            r_s1_data <= i_wdata;
            r_s1_mode <= wmode_e'(i_wmode);
         end
         r_fwd_valid <= w_s1_we;
         r_fwd_addr  <= r_s1_addr;
         r_fwd_data  <= w_new;
      end
   end

   // Buffer A is id 0, buffer B is id 1; each read port serves whichever role its buffer has.
   assign w_raddr_a = r_front_id ? i_waddr : i_scan_addr;
   assign w_raddr_b = r_front_id ? i_scan_addr : i_waddr;
   assign w_we_a    = w_s1_we & r_front_id;
   assign w_we_b    = w_s1_we & ~r_front_id;

   fb_dpram #(
      .COLOR_W (COLOR_W),
      .ADDR_W  (ADDR_W),
      .DEPTH   (DEPTH)
   ) u_buf_a (
      .i_clk   (i_clk),
      .i_we    (w_we_a),
      .i_waddr (r_s1_addr),
      .i_wdata (w_new),
      .i_raddr (w_raddr_a),
      .o_rdata (w_rdata_a)
   );

   fb_dpram #(
      .COLOR_W (COLOR_W),
      .ADDR_W  (ADDR_W),
      .DEPTH   (DEPTH)
   ) u_buf_b (
      .i_clk   (i_clk),
      .i_we    (w_we_b),
      .i_waddr (r_s1_addr),
      .i_wdata (w_new),
      .i_raddr (w_raddr_b),
      .o_rdata (w_rdata_b)
   );

   // Display path: RAM read register, then output register gated by the delayed active flag.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_rd_sel <= 1'b0;
         r_act_d1 <= 1'b0;
         r_pix    <= '0;
      end else begin
         r_rd_sel <= r_front_id;
         r_act_d1 <= i_scan_active;
         r_pix    <= r_act_d1 ? (r_rd_sel ? w_rdata_b : w_rdata_a) : '0;
      end
   end

   assign o_pix = r_pix;

endmodule

// File: tb/tb_fb_rop_dbuf.sv
// Self-checking bench for fb_rop_dbuf: directed scenarios plus randomized raster-op traffic
// checked against a per-buffer pixel map.
module tb_fb_rop_dbuf;

   localparam int ADDR_W = 17;
   localparam int DEPTH  = 320 * 240;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [ADDR_W-1:0] scan_addr = '0;
   logic              scan_active = 1'b0;
   logic              frame_end = 1'b0;
   logic [2:0]        pix;
   logic              wvalid = 1'b0;
   logic              wready;
   logic [ADDR_W-1:0] waddr = '0;
   logic [2:0]        wdata = '0;
   logic [1:0]        wmode = '0;
   logic              flush = 1'b0;
   logic              swap_pending, swap_done, front_id, wr_oor;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference: buffer contents keyed by buf*DEPTH+addr, plus which buffer is displayed.
   logic [2:0] mdl [int];
   int         mdl_front = 0;

   fb_rop_dbuf dut (
      .i_clk          (clk),
      .i_reset_n      (rst_n),
      .i_scan_addr    (scan_addr),
      .i_scan_active  (scan_active),
      .i_frame_end    (frame_end),
      .o_pix          (pix),
      .i_wvalid       (wvalid),
      .o_wready       (wready),
      .i_waddr        (waddr),
      .i_wdata        (wdata),
      .i_wmode        (wmode),
      .i_flush        (flush),
      .o_swap_pending (swap_pending),
      .o_swap_done    (swap_done),
      .o_front_id     (front_id),
      .o_wr_oor       (wr_oor)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete (got timeout, required finish)");
      $fatal(1);
   end

   function automatic logic [2:0] rop_ref(logic [2:0] old, logic [2:0] src, int mode);
      case (mode)
         0:       return src;
         1:       return old & src;
         2:       return old | src;
         default: return old ^ src;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drives one write, waits (bounded) for acceptance, returns in its S1 cycle with o_wr_oor.
   // Payload stays driven so a following call can issue back-to-back.
   task automatic write_px(input int addr, input int data, input int mode,
                           output bit acc, output logic oor);
      int         k;
      int         m;
      logic [2:0] d;
      k = (1 - mdl_front) * DEPTH + addr;
      m = (addr < DEPTH && !mdl.exists(k)) ? 0 : mode;
      d = data[2:0];
      wvalid = 1'b1;
      waddr  = addr[ADDR_W-1:0];
      wdata  = d;
      wmode  = m[1:0];
      acc    = 1'b0;
      for (int c = 0; c < 50 && !acc; c++) begin
         if (wready) acc = 1'b1;
         step();
      end
      oor = wr_oor;
      if (acc && addr < DEPTH) begin
         mdl[k] = rop_ref(mdl.exists(k) ? mdl[k] : 3'b000, d, m);
      end
   endtask

   task automatic idle(input int n);
      wvalid = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_swap(output logic done, output logic front);
      wvalid = 1'b0;
      flush  = 1'b1;
      step();
      flush = 1'b0;
      step();
      step();
      step();
      frame_end = 1'b1;
      step();
      frame_end = 1'b0;
      mdl_front = 1 - mdl_front;
      done  = swap_done;
      front = front_id;
   endtask

   task automatic scan(input int addr, input bit act, output logic [2:0] p);
      scan_addr   = addr[ADDR_W-1:0];
      scan_active = act;
      step();
      scan_active = 1'b0;
      step();
      p = pix;
   endtask

   function automatic logic [2:0] front_exp(int addr);
      int k;
      k = mdl_front * DEPTH + addr;
      return mdl.exists(k) ? mdl[k] : 3'bxxx;
   endfunction

   task automatic test_reset();
      logic [6:0] obs;
      rst_n = 1'b0;
      step();
      step();
      obs = {front_id, pix, swap_pending, swap_done, wr_oor};
      n_cmp++;
      if (obs !== 7'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b required 0000000", obs);
      end
      rst_n = 1'b1;
      n_cmp++;
      if ({wready, swap_pending} !== 2'b10) begin
         n_fail++;
         $display("FAIL reset_release_wready: got %b required 10", {wready, swap_pending});
      end
   endtask

   task automatic test_basic();
      bit         acc;
      logic       oor, done, front;
      logic [2:0] p;
      write_px(5, 5, 0, acc, oor);
      n_cmp++;
      if ({acc, oor} !== 2'b10) begin
         n_fail++;
         $display("FAIL basic_write: acc/oor got %b required 10", {acc, oor});
      end
      write_px(9, 3, 0, acc, oor);
      idle(1);
      do_swap(done, front);
      n_cmp++;
      if ({done, front} !== {1'b1, 1'(mdl_front)}) begin
         n_fail++;
         $display("FAIL basic_swap: done/front got %b required 1%0d", {done, front}, mdl_front);
      end
      step();
      n_cmp++;
      if (swap_done !== 1'b0) begin
         n_fail++;
         $display("FAIL swap_done_pulse: got %b required 0", swap_done);
      end
      scan(5, 1'b1, p);
      n_cmp++;
      if (p !== 3'b101) begin
         n_fail++;
         $display("FAIL basic_scan: got %b required 101", p);
      end
      scan(5, 1'b0, p);
      n_cmp++;
      if (p !== 3'b000) begin
         n_fail++;
         $display("FAIL scan_inactive: got %b required 000", p);
      end
   endtask

   task automatic test_forwarding();
      bit         acc;
      logic       oor, done, front;
      logic [2:0] p;
      int         addrs[7] = '{0, 9, 9, 9, DEPTH - 1, DEPTH - 1, DEPTH};
      int         datas[7] = '{3, 6, 1, 7, 6, 3, 7};
      int         modes[7] = '{0, 0, 2, 3, 0, 1, 0};
      int         chk[3]   = '{9, DEPTH - 1, 0};
      for (int i = 0; i < 7; i++) begin
         write_px(addrs[i], datas[i], modes[i], acc, oor);
         n_cmp++;
         if ({acc, oor} !== {1'b1, 1'(addrs[i] >= DEPTH)}) begin
            n_fail++;
            $display("FAIL fwd_write[%0d]: acc/oor got %b required 1%0d", i, {acc, oor},
                     addrs[i] >= DEPTH);
         end
      end
      idle(1);
      n_cmp++;
      if (wr_oor !== 1'b0) begin
         n_fail++;
         $display("FAIL oor_pulse_width: got %b required 0", wr_oor);
      end
      do_swap(done, front);
      n_cmp++;
      if ({done, front} !== {1'b1, 1'(mdl_front)}) begin
         n_fail++;
         $display("FAIL fwd_swap: done/front got %b required 1%0d", {done, front}, mdl_front);
      end
      for (int i = 0; i < 3; i++) begin
         scan(chk[i], 1'b1, p);
         n_cmp++;
         if (p !== front_exp(chk[i])) begin
            n_fail++;
            $display("FAIL fwd_scan addr %0d: got %b required %b", chk[i], p, front_exp(chk[i]));
         end
      end
      n_cmp++;
      if (front_exp(9) !== 3'b000 || front_exp(DEPTH - 1) !== 3'b010) begin
         n_fail++;
         $display("FAIL fwd_model: got %b/%b required 000/010", front_exp(9), front_exp(DEPTH - 1));
      end
   endtask

   task automatic test_flush_stall();
      int         early;
      logic [2:0] p;
      logic       done, front;
      flush = 1'b1;
      step();
      flush = 1'b0;
      n_cmp++;
      if ({swap_pending, wready} !== 2'b10) begin
         n_fail++;
         $display("FAIL stall_pending: pending/wready got %b required 10", {swap_pending, wready});
      end
      wvalid = 1'b1;
      waddr  = 17'd9;
      wdata  = 3'b100;
      wmode  = 2'b00;
      early  = 0;
      for (int i = 0; i < 4; i++) begin
         if (wready) early++;
         step();
      end
      frame_end = 1'b1;
      step();
      frame_end = 1'b0;
      mdl_front = 1 - mdl_front;
      n_cmp++;
      if (early !== 0) begin
         n_fail++;
         $display("FAIL stall_wready: got %0d ready cycles required 0", early);
      end
      n_cmp++;
      if ({swap_done, wready, front_id} !== {2'b11, 1'(mdl_front)}) begin
         n_fail++;
         $display("FAIL stall_release: done/wready/front got %b required 11%0d",
                  {swap_done, wready, front_id}, mdl_front);
      end
      step();
      mdl[(1 - mdl_front) * DEPTH + 9] = 3'b100;
      idle(1);
      scan(9, 1'b1, p);
      n_cmp++;
      if (p !== front_exp(9)) begin
         n_fail++;
         $display("FAIL stall_front_intact: got %b required %b", p, front_exp(9));
      end
      do_swap(done, front);
      scan(9, 1'b1, p);
      n_cmp++;
      if (p !== 3'b100) begin
         n_fail++;
         $display("FAIL stall_write_landed: got %b required 100", p);
      end
   endtask

   task automatic test_flush_held();
      int n_done;
      frame_end = 1'b1;
      step();
      frame_end = 1'b0;
      step();
      n_cmp++;
      if ({swap_done, front_id} !== {1'b0, 1'(mdl_front)}) begin
         n_fail++;
         $display("FAIL frame_end_no_flush: done/front got %b required 0%0d",
                  {swap_done, front_id}, mdl_front);
      end
      flush  = 1'b1;
      n_done = 0;
      for (int c = 0; c < 12; c++) begin
         frame_end = (c == 4 || c == 9);
         step();
         if (swap_done) n_done++;
      end
      frame_end = 1'b0;
      flush     = 1'b0;
      mdl_front = 1 - mdl_front;
      step();
      n_cmp++;
      if (n_done !== 1 || front_id !== 1'(mdl_front)) begin
         n_fail++;
         $display("FAIL flush_held: got %0d swaps front %b required 1 swap front %0d",
                  n_done, front_id, mdl_front);
      end
      flush = 1'b1;
      step();
      flush     = 1'b0;
      frame_end = 1'b1;
      step();
      frame_end = 1'b0;
      step();
      n_cmp++;
      if ({swap_done, swap_pending, front_id} !== {2'b01, 1'(mdl_front)}) begin
         n_fail++;
         $display("FAIL frame_end_in_pend: done/pending/front got %b required 01%0d",
                  {swap_done, swap_pending, front_id}, mdl_front);
      end
      frame_end = 1'b1;
      step();
      frame_end = 1'b0;
      mdl_front = 1 - mdl_front;
      n_cmp++;
      if ({swap_done, front_id} !== {1'b1, 1'(mdl_front)}) begin
         n_fail++;
         $display("FAIL swap_after_pend: done/front got %b required 1%0d",
                  {swap_done, front_id}, mdl_front);
      end
   endtask

   task automatic test_random();
      int         pool[8];
      int         a;
      bit         acc;
      logic       oor, done, front;
      logic [2:0] p;
      pool[0] = 0;
      pool[1] = DEPTH - 1;
      for (int i = 2; i < 8; i++) pool[i] = $urandom_range(DEPTH - 2, 1);
      for (int r = 0; r < 4; r++) begin
         for (int w = 0; w < 30; w++) begin
            a = ($urandom_range(9, 0) == 0) ? DEPTH + $urandom_range(100, 0)
                                             : pool[$urandom_range(7, 0)];
            write_px(a, $urandom_range(7, 0), $urandom_range(3, 0), acc, oor);
            n_cmp++;
            if ({acc, oor} !== {1'b1, 1'(a >= DEPTH)}) begin
               n_fail++;
               $display("FAIL rand_write addr %0d: acc/oor got %b required 1%0d", a, {acc, oor},
                        a >= DEPTH);
            end
            if ($urandom_range(1, 0) == 0) idle(1);
         end
         idle(1);
         do_swap(done, front);
         n_cmp++;
         if ({done, front} !== {1'b1, 1'(mdl_front)}) begin
            n_fail++;
            $display("FAIL rand_swap: done/front got %b required 1%0d", {done, front}, mdl_front);
         end
         for (int i = 0; i < 8; i++) begin
            if (mdl.exists(mdl_front * DEPTH + pool[i])) begin
               scan(pool[i], 1'b1, p);
               n_cmp++;
               if (p !== front_exp(pool[i])) begin
                  n_fail++;
                  $display("FAIL rand_scan addr %0d: got %b required %b", pool[i], p,
                           front_exp(pool[i]));
               end
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      bit         acc;
      logic       oor, done, front;
      logic [2:0] p;
      logic [7:0] obs;
      if (mdl_front == 0) do_swap(done, front);
      write_px(0, 6, 0, acc, oor);
      idle(2);
      wvalid = 1'b1;
      waddr  = '0;
      wdata  = 3'b001;
      wmode  = 2'b11;
      n_cmp++;
      if (wready !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_accept: wready got %b required 1", wready);
      end
      step();
      wvalid = 1'b0;
      rst_n  = 1'b0;
      #1;
      obs = {front_id, pix, swap_pending, swap_done, wr_oor, wready};
      n_cmp++;
      if (obs !== 8'b0000_0001) begin
         n_fail++;
         $display("FAIL reset_mid_rmw: outputs got %b required 00000001", obs);
      end
      step();
      rst_n     = 1'b1;
      mdl_front = 0;
      step();
      scan(0, 1'b1, p);
      n_cmp++;
      if (p !== 3'b110) begin
         n_fail++;
         $display("FAIL aborted_write_dropped: got %b required 110", p);
      end
      do_swap(done, front);
      flush = 1'b1;
      step();
      flush = 1'b0;
      step();
      step();
      rst_n = 1'b0;
      #1;
      obs = {front_id, pix, swap_pending, swap_done, wr_oor, wready};
      n_cmp++;
      if (obs !== 8'b0000_0001) begin
         n_fail++;
         $display("FAIL reset_in_drain: outputs got %b required 00000001", obs);
      end
      step();
      rst_n     = 1'b1;
      mdl_front = 0;
      frame_end = 1'b1;
      step();
      frame_end = 1'b0;
      n_cmp++;
      if ({swap_done, front_id, swap_pending} !== 3'b000) begin
         n_fail++;
         $display("FAIL drain_cancelled: done/front/pending got %b required 000",
                  {swap_done, front_id, swap_pending});
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_forwarding();
      test_flush_stall();
      test_flush_held();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/fb_rop_dbuf.md
Name: fb_rop_dbuf

Overview:
- Parametrised double-buffered frame store with raster-op writes: replace, AND, OR, XOR.
- Sits between the drawing master and the VGA path.
- The drawing side writes to the back buffer through a valid/ready read-modify-write pipeline.
- The display side reads the front buffer at the scan address supplied by the CRCT timing generator.
- A buffer swap is requested by the drawer and committed only at frame end, so there is no tearing.

Parameters:
- COLOR_W, 3, bits per pixel
- H_RES, 320, stored pixels per line
- V_RES, 240, stored lines
- DEPTH, H_RES*V_RES, words per buffer (derived; not overridden)
- ADDR_W, 17, address width; must satisfy 2**ADDR_W >= DEPTH

Ports:
- i_clk, in, 1, system clock
- i_reset_n, in, 1, asynchronous active-low reset
- i_scan_addr, in, ADDR_W, current display pixel address from CRCT
- i_scan_active, in, 1, CRCT active-video flag
- i_frame_end, in, 1, one-cycle pulse at end of visible frame
- o_pix, out, COLOR_W, front-buffer pixel; 0 when not active
- i_wvalid, in, 1, write request valid
- o_wready, out, 1, write request accepted this cycle when high together with i_wvalid
- i_waddr, in, ADDR_W, back-buffer pixel address
- i_wdata, in, COLOR_W, source colour
- i_wmode, in, 2, 00 replace, 01 AND, 10 OR, 11 XOR
- i_flush, in, 1, swap request, level or pulse
- o_swap_pending, out, 1, swap requested, not yet committed
- o_swap_done, out, 1, one-cycle pulse on commit
- o_front_id, out, 1, index of the displayed buffer
- o_wr_oor, out, 1, one-cycle pulse when an accepted write had i_waddr >= DEPTH

Behaviour:
Reset (asynchronous, i_reset_n=0):
- o_front_id=0, o_pix=0, o_swap_pending=0, o_swap_done=0, o_wr_oor=0.
- Pipeline empty; o_wready=1 in the first cycle after release.
- RAM contents are not cleared.
- Reset asserted mid-RMW discards the in-flight write.

Display path:
- Front RAM read port is addressed by i_scan_addr.
- Synchronous read, then output register: 2-cycle latency.
- i_scan_active is delayed 2 cycles to match; o_pix = pixel if the delayed active flag = 1, else 0.
- The read mux selects the buffer by o_front_id, sampled in the same cycle as the address.

Write pipeline (2 stages, throughput 1 per cycle):
- S0: accept when i_wvalid & o_wready. Register addr/data/mode and issue a back-buffer read at i_waddr.
- S1: old = RAM read data, or the forwarded S1 result when the previous S1 wrote the same address (back-to-back RMW hazard).
- S1 computes new = wdata / old&wdata / old|wdata / old^wdata and writes the back buffer (buffer ~o_front_id).
- Addresses >= DEPTH: accepted, no RAM write, o_wr_oor pulses in the S1 cycle.
- Replace mode still issues the read; there is no shortcut.

Swap FSM (IDLE, PEND, DRAIN):
- IDLE: rising edge of i_flush -> PEND. o_swap_pending=1 from the next cycle, and o_wready=0 from the same cycle.
- PEND: wait for S1 to be empty (at most 1 cycle), then -> DRAIN.
- DRAIN: on i_frame_end -> toggle o_front_id, pulse o_swap_done, -> IDLE. o_swap_pending=0 and o_wready=1 from the next cycle.
- If i_frame_end arrives in PEND, it is ignored and the swap waits for the next frame end.
- i_flush held high does not retrigger; a new rising edge is required.
- A flush edge while not IDLE is ignored.
- i_frame_end with no pending swap: no effect.

Boundaries:
- Writes stalled by o_wready=0 must hold i_wvalid and their payload (standard valid/ready).
- Address DEPTH-1 is valid; DEPTH flags o_wr_oor.
- Scan addresses >= DEPTH return undefined data, which is acceptable because CRCT never drives them while active.

Decomposition:
- Package fb_pkg: wmode_e enum (WM_REPLACE, WM_AND, WM_OR, WM_XOR), swap_state_e (IDLE, PEND, DRAIN), function rop(old, src, mode).
- One sub-module: fb_dpram, a simple dual-port RAM (1 write port, 1 registered read port) parametrised by COLOR_W, ADDR_W, DEPTH.
- fb_rop_dbuf instantiates fb_dpram twice.

Test Plan:
- Reset, write replace addr 5 = 3'b101, flush, frame_end -> o_swap_done pulse, o_front_id=1, o_pix=3'b101 two cycles after i_scan_addr=5 with active=1.
- Back buffer holds 3'b110 at addr 9; issue OR 3'b001, then back-to-back XOR 3'b111 at addr 9 -> after swap addr 9 reads 3'b000 (forwarding exercised).
- AND 3'b011 onto 3'b110 at addr DEPTH-1 -> 3'b010; write at addr DEPTH -> o_wr_oor pulse, no RAM change.
- Flush rising edge with i_wvalid held -> o_wready low until o_swap_done. Held write lands in the new back buffer (old front), and the displayed frame is unchanged.
- i_flush held high across two frame_ends -> exactly one swap. i_frame_end with no flush -> o_front_id stable.
- Assert i_reset_n low mid-RMW and during DRAIN -> all outputs at reset values immediately, o_front_id=0, no RAM write from the aborted op.
